// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - N-port memory arbiter onto a single downstream memory port
//
// Merges NPORT requesters that use the core's valid/instr/addr/wdata/wstrb ->
// rdata/ready memory protocol onto one downstream port. One transaction is
// outstanding at a time. A request strobe that cannot be issued at once is
// captured in a per-port pend latch. Arbitration is either round-robin or fixed
// priority, where the lowest index wins.
//
// Ports:
//   clock, reset        system clock; synchronous active-high reset
//   req_valid[i]        one-cycle request strobe of port i
//   req_instr[i]        instruction-fetch flag of port i
//   req_addr/wdata      32 bits per port, port i at [32i+31:32i]
//   req_wstrb           4 bits per port, all zero means read
//   resp_rdata          downstream read data, broadcast to every port
//   resp_ready          one-hot completion pulse for the granted port
//   mem_valid           one-cycle downstream request pulse per issue
//   mem_instr/addr/wdata/wstrb  registered fields of the last issue
//   mem_rdata, mem_ready        downstream response

module mem_arbiter #(
  parameter int NPORT         = 2,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NPORT-1:0]    req_valid,
  input  logic [NPORT-1:0]    req_instr,
  input  logic [32*NPORT-1:0] req_addr,
  input  logic [32*NPORT-1:0] req_wdata,
  input  logic [4*NPORT-1:0]  req_wstrb,
  output logic [31:0]         resp_rdata,
  output logic [NPORT-1:0]    resp_ready,
  output logic                mem_valid,
  output logic                mem_instr,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  output logic [3:0]          mem_wstrb,
  input  logic [31:0]         mem_rdata,
  input  logic                mem_ready
);

  localparam int            PW   = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam logic [PW-1:0] LAST = PW'(NPORT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    grant_q, grant_d;

  logic             mem_valid_q, mem_valid_d;
  logic             mem_instr_q, mem_instr_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [3:0]       mem_wstrb_q, mem_wstrb_d;

  logic [NPORT-1:0] pend_valid_q, pend_valid_d;
  logic [NPORT-1:0] pend_instr_q, pend_instr_d;
  logic [31:0]      pend_addr_q  [NPORT];
  logic [31:0]      pend_addr_d  [NPORT];
  logic [31:0]      pend_wdata_q [NPORT];
  logic [31:0]      pend_wdata_d [NPORT];
  logic [3:0]       pend_wstrb_q [NPORT];
  logic [3:0]       pend_wstrb_d [NPORT];

  // Effective request per port: an accepted live strobe or the pend latch.
  logic [NPORT-1:0] live;
  logic [NPORT-1:0] eff;
  logic [NPORT-1:0] eff_instr;
  logic [31:0]      eff_addr  [NPORT];
  logic [31:0]      eff_wdata [NPORT];
  logic [3:0]       eff_wstrb [NPORT];

  logic             win_found;
  logic [PW-1:0]    win_idx;
  logic             issue;

  always_comb begin
    live      = '0;
    eff       = '0;
    eff_instr = '0;
    for (int i = 0; i < NPORT; i++) begin
      eff_instr[i] = pend_instr_q[i];
      eff_addr[i]  = pend_addr_q[i];
      eff_wdata[i] = pend_wdata_q[i];
      eff_wstrb[i] = pend_wstrb_q[i];
      // A repeated strobe is dropped while the port still owns a pend entry
      // or an in-flight request. The in-flight one stops counting in the
      // cycle it completes, so a port may re-request on its resp_ready.
      live[i] = req_valid[i] && !pend_valid_q[i] &&
                !(state_q == S_BUSY && grant_q == PW'(i) && !mem_ready);
      if (live[i]) begin
        eff_instr[i] = req_instr[i];
        eff_addr[i]  = req_addr[32*i +: 32];
        eff_wdata[i] = req_wdata[32*i +: 32];
        eff_wstrb[i] = req_wstrb[4*i +: 4];
      end
      eff[i] = live[i] | pend_valid_q[i];
    end
  end

  // Winner select. Both loops run from the far end back towards the
  // preferred start, so the last hit is the one nearest the start.
  always_comb begin : p_pick
    logic [PW-1:0] cand;
    int            rot;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    rot       = 0;
    if (PRIORITY_MODE != 0) begin
      for (int i = NPORT - 1; i >= 0; i--) begin
        if (eff[i]) begin
          win_found = 1'b1;
          win_idx   = PW'(i);
        end
      end
    end else begin
      for (int off = NPORT - 1; off >= 0; off--) begin
        rot = int'(ptr_q) + off;
        if (rot >= NPORT) begin
          rot = rot - NPORT;
        end
        cand = PW'(rot);
        if (eff[cand]) begin
          win_found = 1'b1;
          win_idx   = cand;
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    mem_valid_d  = 1'b0;
    mem_instr_d  = mem_instr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    pend_valid_d = pend_valid_q;
    pend_instr_d = pend_instr_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    pend_wstrb_d = pend_wstrb_q;
    issue        = 1'b0;

    case (state_q)
      S_IDLE: begin
        issue = win_found;
      end
      S_BUSY: begin
        // Completion and the next issue share a cycle: no idle bubble.
        if (mem_ready) begin
          issue = win_found;
          if (!win_found) begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (issue) begin
      state_d     = S_BUSY;
      grant_d     = win_idx;
      ptr_d       = (win_idx == LAST) ? '0 : win_idx + PW'(1);
      mem_valid_d = 1'b1;
      mem_instr_d = eff_instr[win_idx];
      mem_addr_d  = eff_addr[win_idx];
      mem_wdata_d = eff_wdata[win_idx];
      mem_wstrb_d = eff_wstrb[win_idx];
    end

    // Granted ports drop their latch; accepted strobes that lost are kept.
    for (int i = 0; i < NPORT; i++) begin
      if (issue && win_idx == PW'(i)) begin
        pend_valid_d[i] = 1'b0;
      end else if (live[i]) begin
        pend_valid_d[i] = 1'b1;
        pend_instr_d[i] = req_instr[i];
        pend_addr_d[i]  = req_addr[32*i +: 32];
        pend_wdata_d[i] = req_wdata[32*i +: 32];
        pend_wstrb_d[i] = req_wstrb[4*i +: 4];
      end
    end
  end

  // mem_ready is only meaningful while a transaction is outstanding.
  always_comb begin
    resp_ready = '0;
    if (state_q == S_BUSY && mem_ready) begin
      resp_ready[grant_q] = 1'b1;
    end
  end

  assign resp_rdata = mem_rdata;
  assign mem_valid  = mem_valid_q;
  assign mem_instr  = mem_instr_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      grant_q      <= '0;
      mem_valid_q  <= 1'b0;
      mem_instr_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      pend_valid_q <= '0;
      pend_instr_q <= '0;
      for (int i = 0; i < NPORT; i++) begin
        pend_addr_q[i]  <= '0;
        pend_wdata_q[i] <= '0;
        pend_wstrb_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      mem_valid_q  <= mem_valid_d;
      mem_instr_q  <= mem_instr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      pend_valid_q <= pend_valid_d;
      pend_instr_q <= pend_instr_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      pend_wstrb_q <= pend_wstrb_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter (round-robin and fixed priority)

module tb_mem_arbiter;

  typedef struct {
    int          cyc;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } iss_t;

  typedef struct {
    int          cyc;
    logic [7:0]  rdy;
    logic [31:0] rdata;
  } rsp_t;

  logic clk;
  logic rst_a, rst_b;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  // instance A: NPORT=2 round-robin
  logic [1:0]  rv_a, ri_a, rr_a;
  logic [63:0] ra_a, rw_a;
  logic [7:0]  rs_a;
  logic [31:0] rrd_a, ma_a, mw_a, mrd_a;
  logic        mv_a, mi_a, mr_a, mr_resp_a, mr_man_a;
  logic [3:0]  ms_a;

  // instance B: NPORT=3 fixed priority
  logic [2:0]  rv_b, ri_b, rr_b;
  logic [95:0] ra_b, rw_b;
  logic [11:0] rs_b;
  logic [31:0] rrd_b, ma_b, mw_b, mrd_b;
  logic        mv_b, mi_b, mr_b, mr_resp_b;
  logic [3:0]  ms_b;

  assign mr_a = mr_resp_a | mr_man_a;
  assign mr_b = mr_resp_b;

  iss_t iss_q_a[$], iss_q_b[$];
  rsp_t rsp_q_a[$], rsp_q_b[$];

  logic chk_rst_a, chk_rst_b, chk_quiet_a, chk_final;
  logic en_a, en_b;
  int   lat_a, lat_b;

  mem_arbiter #(.NPORT(2), .PRIORITY_MODE(0)) u_rr (
    .clock(clk), .reset(rst_a),
    .req_valid(rv_a), .req_instr(ri_a), .req_addr(ra_a), .req_wdata(rw_a), .req_wstrb(rs_a),
    .resp_rdata(rrd_a), .resp_ready(rr_a),
    .mem_valid(mv_a), .mem_instr(mi_a), .mem_addr(ma_a), .mem_wdata(mw_a), .mem_wstrb(ms_a),
    .mem_rdata(mrd_a), .mem_ready(mr_a)
  );

  mem_arbiter #(.NPORT(3), .PRIORITY_MODE(1)) u_fp (
    .clock(clk), .reset(rst_b),
    .req_valid(rv_b), .req_instr(ri_b), .req_addr(ra_b), .req_wdata(rw_b), .req_wstrb(rs_b),
    .resp_rdata(rrd_b), .resp_ready(rr_b),
    .mem_valid(mv_b), .mem_instr(mi_b), .mem_addr(ma_b), .mem_wdata(mw_b), .mem_wstrb(ms_b),
    .mem_rdata(mrd_b), .mem_ready(mr_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // memory contents seen by both instances
  function automatic logic [31:0] rdfn(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
  endfunction

  // downstream memory models: mem_ready lat cycles after the mem_valid cycle
  logic        act_a, act_b;
  int          cnt_a, cnt_b;
  logic [31:0] rd_a, rd_b;

  always @(posedge clk) begin
    #2;
    mr_resp_a = 1'b0;
    if (!en_a) act_a = 1'b0;
    else begin
      if (mv_a) begin act_a = 1'b1; cnt_a = lat_a; rd_a = rdfn(ma_a); end
      if (act_a) begin
        if (cnt_a == 0) begin mr_resp_a = 1'b1; mrd_a = rd_a; act_a = 1'b0; end
        else cnt_a = cnt_a - 1;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    mr_resp_b = 1'b0;
    if (!en_b) act_b = 1'b0;
    else begin
      if (mv_b) begin act_b = 1'b1; cnt_b = lat_b; rd_b = rdfn(ma_b); end
      if (act_b) begin
        if (cnt_b == 0) begin mr_resp_b = 1'b1; mrd_b = rd_b; act_b = 1'b0; end
        else cnt_b = cnt_b - 1;
      end
    end
  end

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] req);
    n_vec++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic mon_iss(input int w, input logic instr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
    iss_t e;
    logic have;
    have = 1'b0;
    n_vec++;
    if (w == 0 && iss_q_a.size() > 0) begin e = iss_q_a.pop_front(); have = 1'b1; end
    if (w == 1 && iss_q_b.size() > 0) begin e = iss_q_b.pop_front(); have = 1'b1; end
    if (!have) begin
      n_err++;
      $display("FAIL issue_%0d_unexpected: got cyc=%0d addr=%h, required no issue", w, cyc, addr);
    end else if (e.cyc != cyc || e.instr !== instr || e.addr !== addr ||
                 e.wdata !== wdata || e.wstrb !== wstrb) begin
      n_err++;
      $display("FAIL issue_%0d: got cyc=%0d instr=%0b addr=%h wdata=%h wstrb=%h, required cyc=%0d instr=%0b addr=%h wdata=%h wstrb=%h",
               w, cyc, instr, addr, wdata, wstrb, e.cyc, e.instr, e.addr, e.wdata, e.wstrb);
    end
  endtask

  task automatic mon_rsp(input int w, input logic [7:0] rdy, input logic [31:0] rdata);
    rsp_t e;
    logic have;
    have = 1'b0;
    n_vec++;
    if (w == 0 && rsp_q_a.size() > 0) begin e = rsp_q_a.pop_front(); have = 1'b1; end
    if (w == 1 && rsp_q_b.size() > 0) begin e = rsp_q_b.pop_front(); have = 1'b1; end
    if (!have) begin
      n_err++;
      $display("FAIL resp_%0d_unexpected: got cyc=%0d resp_ready=%b, required none", w, cyc, rdy);
    end else if (e.cyc != cyc || e.rdy !== rdy || e.rdata !== rdata) begin
      n_err++;
      $display("FAIL resp_%0d: got cyc=%0d resp_ready=%b rdata=%h, required cyc=%0d resp_ready=%b rdata=%h",
               w, cyc, rdy, rdata, e.cyc, e.rdy, e.rdata);
    end
  endtask

  // monitor: compares DUT outputs against the scoreboard away from the edge
  always @(negedge clk) begin
    if (mv_a) mon_iss(0, mi_a, ma_a, mw_a, ms_a);
    if (rr_a != 2'b00) mon_rsp(0, {6'b0, rr_a}, rrd_a);
    if (mv_b) mon_iss(1, mi_b, ma_b, mw_b, ms_b);
    if (rr_b != 3'b000) mon_rsp(1, {5'b0, rr_b}, rrd_b);
    if (chk_rst_a) begin
      cmp("rst_a_mem_valid", 32'(mv_a), 32'h0);
      cmp("rst_a_mem_instr", 32'(mi_a), 32'h0);
      cmp("rst_a_mem_addr", ma_a, 32'h0);
      cmp("rst_a_mem_wdata", mw_a, 32'h0);
      cmp("rst_a_mem_wstrb", 32'(ms_a), 32'h0);
      cmp("rst_a_resp_ready", 32'(rr_a), 32'h0);
    end
    if (chk_rst_b) begin
      cmp("rst_b_mem_valid", 32'(mv_b), 32'h0);
      cmp("rst_b_mem_addr", ma_b, 32'h0);
      cmp("rst_b_resp_ready", 32'(rr_b), 32'h0);
    end
    if (chk_quiet_a) begin
      cmp("quiet_a_mem_valid", 32'(mv_a), 32'h0);
      cmp("quiet_a_resp_ready", 32'(rr_a), 32'h0);
    end
    if (chk_final) begin
      cmp("left_issue_a", iss_q_a.size(), 32'h0);
      cmp("left_resp_a", rsp_q_a.size(), 32'h0);
      cmp("left_issue_b", iss_q_b.size(), 32'h0);
      cmp("left_resp_b", rsp_q_b.size(), 32'h0);
    end
  end

  task automatic exp_iss(input int w, input int c, input logic instr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
    iss_t e;
    e.cyc = c; e.instr = instr; e.addr = addr; e.wdata = wdata; e.wstrb = wstrb;
    if (w == 0) iss_q_a.push_back(e);
    else iss_q_b.push_back(e);
  endtask

  task automatic exp_rsp(input int w, input int c, input logic [7:0] rdy, input logic [31:0] rdata);
    rsp_t e;
    e.cyc = c; e.rdy = rdy; e.rdata = rdata;
    if (w == 0) rsp_q_a.push_back(e);
    else rsp_q_b.push_back(e);
  endtask

  task automatic set_a(input int p, input logic instr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
    rv_a[p] = 1'b1; ri_a[p] = instr;
    ra_a[32*p +: 32] = addr; rw_a[32*p +: 32] = wdata; rs_a[4*p +: 4] = wstrb;
  endtask

  task automatic set_b(input int p, input logic [31:0] addr);
    rv_b[p] = 1'b1; ri_b[p] = 1'b0;
    ra_b[32*p +: 32] = addr; rw_b[32*p +: 32] = 32'h0; rs_b[4*p +: 4] = 4'h0;
  endtask

  // inputs change 1 time unit after the rising edge; one-cycle strobes drop here
  task automatic step();
    @(posedge clk);
    #1;
    rv_a = '0; rv_b = '0; mr_man_a = 1'b0;
    chk_rst_a = 1'b0; chk_rst_b = 1'b0; chk_quiet_a = 1'b0; chk_final = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: cyc=%0d, required end of test", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

  initial begin
    int t;
    rv_a = '0; ri_a = '0; ra_a = '0; rw_a = '0; rs_a = '0; mr_man_a = 1'b0;
    rv_b = '0; ri_b = '0; ra_b = '0; rw_b = '0; rs_b = '0;
    chk_rst_a = 1'b0; chk_rst_b = 1'b0; chk_quiet_a = 1'b0; chk_final = 1'b0;
    en_a = 1'b1; en_b = 1'b1; lat_a = 0; lat_b = 1;
    rst_a = 1'b1; rst_b = 1'b1;
    idle(3);
    rst_a = 1'b0; rst_b = 1'b0;
    chk_rst_a = 1'b1; chk_rst_b = 1'b1;
    step();

    // single read, zero-wait memory
    t = cyc;
    set_a(0, 1'b0, 32'h100, 32'h0, 4'h0);
    exp_iss(0, t + 1, 1'b0, 32'h100, 32'h0, 4'h0);
    exp_rsp(0, t + 1, 8'b01, 32'hDEADBEEF);
    step(); idle(4);
    rst_a = 1'b1; step(); rst_a = 1'b0; step();

    // round-robin: simultaneous requests, 2-cycle memory
    lat_a = 2;
    t = cyc;
    set_a(0, 1'b0, 32'h10, 32'h0, 4'h0);
    set_a(1, 1'b0, 32'h20, 32'h0, 4'h0);
    exp_iss(0, t + 1, 1'b0, 32'h10, 32'h0, 4'h0);
    exp_rsp(0, t + 3, 8'b01, 32'h5A5A0010);
    exp_iss(0, t + 4, 1'b0, 32'h20, 32'h0, 4'h0);
    exp_rsp(0, t + 6, 8'b10, 32'h5A5A0020);
    step(); idle(8);

    // pointer back at 0 after granting port1: port0 first again
    t = cyc;
    set_a(0, 1'b0, 32'h30, 32'h0, 4'h0);
    set_a(1, 1'b0, 32'h40, 32'h0, 4'h0);
    exp_iss(0, t + 1, 1'b0, 32'h30, 32'h0, 4'h0);
    exp_rsp(0, t + 3, 8'b01, 32'h5A5A0030);
    exp_iss(0, t + 4, 1'b0, 32'h40, 32'h0, 4'h0);
    exp_rsp(0, t + 6, 8'b10, 32'h5A5A0040);
    step(); idle(8);

    // port0 alone moves the pointer to 1, then port1 wins the tie
    t = cyc;
    set_a(0, 1'b0, 32'h50, 32'h0, 4'h0);
    exp_iss(0, t + 1, 1'b0, 32'h50, 32'h0, 4'h0);
    exp_rsp(0, t + 3, 8'b01, 32'h5A5A0050);
    step(); idle(5);
    t = cyc;
    set_a(0, 1'b0, 32'h60, 32'h0, 4'h0);
    set_a(1, 1'b0, 32'h70, 32'h0, 4'h0);
    exp_iss(0, t + 1, 1'b0, 32'h70, 32'h0, 4'h0);
    exp_rsp(0, t + 3, 8'b10, 32'h5A5A0070);
    exp_iss(0, t + 4, 1'b0, 32'h60, 32'h0, 4'h0);
    exp_rsp(0, t + 6, 8'b01, 32'h5A5A0060);
    step(); idle(8);

    // write pulse captured while port0 is in flight; port0 repeat strobe dropped
    lat_a = 5;
    t = cyc;
    set_a(0, 1'b1, 32'h200, 32'h0, 4'h0);
    exp_iss(0, t + 1, 1'b1, 32'h200, 32'h0, 4'h0);
    exp_rsp(0, t + 6, 8'b01, 32'h5A5A0200);
    step(); step();
    set_a(1, 1'b0, 32'h300, 32'hA5A5A5A5, 4'hF);
    exp_iss(0, t + 7, 1'b0, 32'h300, 32'hA5A5A5A5, 4'hF);
    exp_rsp(0, t + 12, 8'b10, 32'h5A5A0300);
    step();
    set_a(0, 1'b0, 32'h999, 32'h0, 4'h0);
    step(); idle(12);

    // reset while busy with port1 pending; late mem_ready must be ignored
    en_a = 1'b0;
    t = cyc;
    set_a(0, 1'b0, 32'h400, 32'h0, 4'h0);
    exp_iss(0, t + 1, 1'b0, 32'h400, 32'h0, 4'h0);
    step();
    set_a(1, 1'b0, 32'h410, 32'h0, 4'h0);
    step();
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    chk_rst_a = 1'b1; chk_quiet_a = 1'b1; mr_man_a = 1'b1;
    step();
    for (int k = 0; k < 6; k++) begin
      chk_quiet_a = 1'b1;
      step();
    end
    en_a = 1'b1;

    // mem_ready while idle: no response, arbiter still issues normally
    mr_man_a = 1'b1; chk_quiet_a = 1'b1;
    step();
    lat_a = 1;
    t = cyc;
    set_a(1, 1'b0, 32'h500, 32'h0, 4'h0);
    exp_iss(0, t + 1, 1'b0, 32'h500, 32'h0, 4'h0);
    exp_rsp(0, t + 2, 8'b10, 32'h5A5A0500);
    step(); idle(4);

    // fixed priority: port0 re-requests on each resp_ready and starves 1 and 2
    t = cyc;
    set_b(0, 32'h1000); set_b(1, 32'h1100); set_b(2, 32'h1200);
    exp_iss(1, t + 1, 1'b0, 32'h1000, 32'h0, 4'h0);
    exp_rsp(1, t + 2, 8'b001, 32'h5A5A1000);
    exp_iss(1, t + 3, 1'b0, 32'h1004, 32'h0, 4'h0);
    exp_rsp(1, t + 4, 8'b001, 32'h5A5A1004);
    exp_iss(1, t + 5, 1'b0, 32'h1008, 32'h0, 4'h0);
    exp_rsp(1, t + 6, 8'b001, 32'h5A5A1008);
    exp_iss(1, t + 7, 1'b0, 32'h1100, 32'h0, 4'h0);
    exp_rsp(1, t + 8, 8'b010, 32'h5A5A1100);
    exp_iss(1, t + 9, 1'b0, 32'h1200, 32'h0, 4'h0);
    exp_rsp(1, t + 10, 8'b100, 32'h5A5A1200);
    step(); step();
    set_b(0, 32'h1004);
    step(); step();
    set_b(0, 32'h1008);
    step(); idle(10);

    chk_final = 1'b1;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
